// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX frame sequencer.
// Optional feature macro used by the top: UART_TX_BREAK_EN (adds BREAK input).
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_par_calc.sv
// Combinational parity bit for a latched UART data word.
module uart_tx_par_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (par_typ == PAR_EVEN) ? ^data : ~^data;

endmodule

// File: rtl/uart_tx_frame_seq.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, 1/2 stop bits.
// Macro UART_TX_BREAK_EN adds a BREAK input that holds the line low while idle.
//
// state     | meaning
// ST_IDLE   | line high (or low during break), waiting for DATA_VALID
// ST_START  | start bit
// ST_DATA   | data bits, bit_cnt selects the bit
// ST_PARITY | parity bit
// ST_STOP1  | first stop bit
// ST_STOP2  | second stop bit
module uart_tx_frame_seq
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
    input  logic                  BREAK,
`endif
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] sh_data_q, sh_data_d;
    logic                  sh_par_en_q, sh_par_en_d;
    logic                  sh_par_typ_q, sh_par_typ_d;
    logic                  sh_stop2_q, sh_stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  final_stop, accept, brk, par_bit;

`ifdef UART_TX_BREAK_EN
    assign brk = BREAK;
`else
    assign brk = 1'b0;
`endif

    uart_tx_par_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par_calc (
        .data    (sh_data_q),
        .par_typ (sh_par_typ_q),
        .par_bit (par_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            sh_data_q    <= '0;
            sh_par_en_q  <= 1'b0;
            sh_par_typ_q <= 1'b0;
            sh_stop2_q   <= 1'b0;
            tx_q         <= IDLE_LVL;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sh_data_q    <= sh_data_d;
            sh_par_en_q  <= sh_par_en_d;
            sh_par_typ_q <= sh_par_typ_d;
            sh_stop2_q   <= sh_stop2_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sh_data_d    = sh_data_q;
        sh_par_en_d  = sh_par_en_q;
        sh_par_typ_d = sh_par_typ_q;
        sh_stop2_d   = sh_stop2_q;
        tx_d         = IDLE_LVL;
        busy_d       = 1'b0;

        final_stop = ((state_q == ST_STOP1) && !sh_stop2_q) || (state_q == ST_STOP2);
        accept     = DATA_VALID && (((state_q == ST_IDLE) && !brk) || final_stop);

        case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_START: begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
            end
            ST_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = sh_par_en_q ? ST_PARITY : ST_STOP1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: state_d = ST_STOP1;
            ST_STOP1:  state_d = sh_stop2_q ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d      = ST_START;
            sh_data_d    = P_DATA;
            sh_par_en_d  = PAR_EN;
            sh_par_typ_d = PAR_TYP;
            sh_stop2_d   = STOP2;
        end

        // Line level is computed for the upcoming state so TX_OUT comes straight from a flop.
        case (state_d)
            ST_START:  tx_d = START_LVL;
            ST_DATA:   tx_d = sh_data_q[bit_cnt_d];
            ST_PARITY: tx_d = par_bit;
            default:   tx_d = IDLE_LVL;
        endcase
        busy_d = (state_d != ST_IDLE);

        if ((state_q == ST_IDLE) && brk) begin
            tx_d   = START_LVL;
            busy_d = 1'b1;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_seq.sv
// Scoreboard bench for uart_tx_frame_seq: expected line bits are queued at acceptance
// and a monitor compares TX_OUT/Busy on every falling edge.
module tb_uart_tx_frame_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic       BREAK = 1'b0;
`endif
    logic       TX_OUT;
    logic       Busy;

    logic exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_tx_frame_seq #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
`ifdef UART_TX_BREAK_EN
        .BREAK      (BREAK),
`endif
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic push_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
    endtask

    task automatic check_now(input string name, input logic tx_exp, input logic busy_exp);
        checks++;
        if (TX_OUT !== tx_exp || Busy !== busy_exp) begin
            errors++;
            $display("FAIL %s: got tx=%b busy=%b, need tx=%b busy=%b", name, TX_OUT, Busy, tx_exp, busy_exp);
        end
    endtask

    // Issues one request, queues the hand-computed frame, scrambles inputs, waits the frame out.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2,
                        input logic [15:0] bits, input int n);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; DATA_VALID = 1'b1;
        @(posedge CLK);
        push_bits(bits, n);
        #1;
        DATA_VALID = 1'b0;
        P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; STOP2 = ~s2;
        repeat (n + 2) @(posedge CLK);
    endtask

    initial begin
        fork
            begin : monitor
                logic tx_e, busy_e;
                forever begin
                    @(negedge CLK);
                    if (exp_q.size() > 0) begin
                        tx_e = exp_q.pop_front();
                        busy_e = 1'b1;
                    end else begin
                        tx_e = 1'b1;
                        busy_e = 1'b0;
                    end
                    check_now("line", tx_e, busy_e);
                end
            end
            begin : stimulus
                repeat (3) @(posedge CLK);
                #2 RST = 1'b1;
                repeat (3) @(posedge CLK);

                // A5, no parity, one stop
                send(8'hA5, 1'b0, 1'b0, 1'b0, 16'b0101001011, 10);
                // 01 even parity -> parity bit 1
                send(8'h01, 1'b1, 1'b0, 1'b0, 16'b01000000011, 11);
                // 01 odd parity -> parity bit 0
                send(8'h01, 1'b1, 1'b1, 1'b0, 16'b01000000001, 11);
                // FF even parity, two stops
                send(8'hFF, 1'b1, 1'b0, 1'b1, 16'b011111111011, 12);

                // Reset during data bit 3
                @(negedge CLK);
                P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
                @(posedge CLK);
                push_bits(16'b0101001011, 10);
                #1 DATA_VALID = 1'b0;
                repeat (4) @(posedge CLK);
                #2 RST = 1'b0;
                #1 check_now("async_reset", 1'b1, 1'b0);
                exp_q.delete();
                repeat (3) @(posedge CLK);
                #2 RST = 1'b1;
                repeat (6) @(posedge CLK);

                // Back-to-back 55 then 0F with mid-frame valid pulses
                @(negedge CLK);
                P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
                @(posedge CLK);
                push_bits(16'b0101010101, 10);
                push_bits(16'b0111100001, 10);
                #1 P_DATA = 8'h0F;
                repeat (10) @(posedge CLK);
                #1 DATA_VALID = 1'b0; P_DATA = 8'hAA;
                repeat (2) @(posedge CLK);
                #1 DATA_VALID = 1'b1;
                @(posedge CLK);
                #1 DATA_VALID = 1'b0;
                repeat (2) @(posedge CLK);
                #1 DATA_VALID = 1'b1;
                @(posedge CLK);
                #1 DATA_VALID = 1'b0;
                repeat (10) @(posedge CLK);

`ifdef UART_TX_BREAK_EN
                @(negedge CLK);
                P_DATA = 8'h33; PAR_EN = 1'b0; STOP2 = 1'b0; BREAK = 1'b1; DATA_VALID = 1'b1;
                @(posedge CLK);
                push_bits(16'h0000, 16);
                push_bits(16'h0000, 4);
                repeat (19) @(posedge CLK);
                #1 BREAK = 1'b0; DATA_VALID = 1'b0;
                repeat (3) @(posedge CLK);
                send(8'h33, 1'b0, 1'b0, 1'b0, 16'b0110011001, 10);
`endif

                repeat (3) @(posedge CLK);
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL queue_drain: got %0d pending bits, need 0", exp_q.size());
                end
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
